unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port, fixed-latency backing memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage).
- Sequences each access through a small FSM and returns read data with a one-cycle ready pulse.
- Raises a global stall_o so hazard logic can freeze PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- MEM_LAT, 2, backing-memory access latency in cycles; legal range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request; level, held until if_ready_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_ready_o  out  1  one-cycle pulse: fetch done, if_rdata_o valid.
- if_rdata_o  out  DATA_W  fetched instruction; holds until the next IF completion.
- dm_req_i  in  1  data request; level, held until dm_ready_o.
- dm_we_i  in  1  1 = store, 0 = load.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  store data.
- dm_ready_o  out  1  one-cycle pulse: data access done.
- dm_rdata_o  out  DATA_W  load data; 0 after a store.
- mem_en_o  out  1  memory enable.
- mem_we_o  out  1  memory write strobe.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data; valid on the last ACCESS cycle.
- stall_o  out  1  pipeline freeze.

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - FSM goes to IDLE and cnt to 0.
  - All outputs and response registers are 0; last_dm is 0.
  - Reset during ACCESS aborts the access; no write is issued after reset release.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any request is pending, latch sel (IF or DM), addr, we and wdata, set cnt = MEM_LAT-1, and go to ACCESS.
- Arbitration: DM wins, except when both requests are pending and the previous grant was DM (last_dm = 1); then IF wins. last_dm updates on every grant.
- ACCESS:
  - mem_en_o = 1; mem_addr_o and mem_wdata_o are driven from the latched values.
  - mem_we_o = 1 only when cnt == 0 and the latched we = 1, giving exactly one write strobe per store.
  - cnt decrements each cycle. At cnt == 0, capture mem_rdata_i into the selected port's rdata register (DM store captures 0) and go to DONE.
- DONE: pulse the selected port's ready for one cycle, then return to IDLE. No new grant is made in DONE; the minimum gap between accesses is one IDLE cycle.
- Latency: request first seen in IDLE at cycle T → ready at T+MEM_LAT+1. Each access occupies MEM_LAT+2 cycles including IDLE.
- stall_o (combinational) = (if_req_i | dm_req_i) & ~(DONE cycle completing every pending request). For example, in DONE for DM with if_req_i still high, stall_o stays 1.
- Request dropped mid-access: the access still completes, including a store write; the ready pulse is still issued and ignored.
- Address or data changes while granted: ignored; the latched values are used.
- Both ready outputs are never high in the same cycle.
- mem_en_o is 0 outside ACCESS; mem_addr_o and mem_wdata_o are don't-care there (driven 0).

Decomposition:
- Shared package cpu_mem_pkg:
  - state enum {IDLE, ACCESS, DONE}.
  - port-select encoding SEL_IF = 0, SEL_DM = 1.
  - default widths ADDR_W/DATA_W = 32.
- Natural sub-module: mem_lat_counter, a loadable down-counter (4-bit) with a terminal flag; it keeps the FSM free of latency arithmetic.
- Everything else stays inline.

Test Plan:
- Single fetch, MEM_LAT = 2: if_req_i = 1, if_addr_i = 0x0000_0010, memory returns 0x2002_0005 → mem_en_o high for 2 cycles, if_ready_o pulses at T+3, if_rdata_o = 0x2002_0005, stall_o falls in that cycle.
- Store then load to the same address: dm_we_i = 1, addr 0x40, data 0xDEAD_BEEF → exactly one mem_we_o cycle. A following load of 0x40 → dm_rdata_o = 0xDEAD_BEEF; dm_rdata_o = 0 after the store.
- Simultaneous requests with last_dm = 0: DM served first (ready at T+3); IF is granted in the next IDLE (ready at T+7). stall_o stays 1 throughout until T+7.
- Fairness: dm_req_i held continuously with if_req_i high → grants alternate DM, IF, DM, IF; IF is never starved beyond one DM access.
- Reset mid-store: assert rst_i = 0 during the first ACCESS cycle of a store with MEM_LAT = 3 → mem_we_o is never 1, all outputs are 0 immediately, and the FSM is in IDLE after release.
- MEM_LAT = 1 boundary: fetch → a single ACCESS cycle, ready at T+2; a back-to-back second fetch → ready at T+5.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and constants for the unified memory arbiter
package cpu_mem_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 4;
    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_DM = 1'b1;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
endpackage

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: loadable down-counter flagging the last memory access cycle
module mem_lat_counter import cpu_mem_pkg::*; (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    // load on grant, count down while accessing, park at zero
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && cnt != '0) cnt <= cnt - CNT_W'(1);
    assign zero = cnt == '0;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency memory between fetch and data ports
module unified_mem_arbiter import cpu_mem_pkg::*; #(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ready_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ready_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o
);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);
    state_t state, state_nxt;
    logic sel, we_q, last_dm, cnt_zero, grant, grant_dm;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    assign grant    = state == IDLE && (if_req_i || dm_req_i);
    assign grant_dm = dm_req_i && !(if_req_i && last_dm);
    mem_lat_counter u_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (grant),
        .dec      (state == ACCESS),
        .load_val (LAT_M1),
        .zero     (cnt_zero)
    );
    // state register
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) state <= IDLE;
        else state <= state_nxt;
    // next state: one idle cycle is always spent between accesses
    always_comb begin
        state_nxt = state == IDLE   ? (grant ? ACCESS : IDLE) :
                    state == ACCESS ? (cnt_zero ? DONE : ACCESS) : IDLE;
    end
    // latch the granted request and capture the response on the last access cycle
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            sel        <= SEL_IF;
            we_q       <= 1'b0;
            last_dm    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_o <= '0;
            dm_rdata_o <= '0;
        end else begin
            if (grant) begin
                sel     <= grant_dm ? SEL_DM : SEL_IF;
                we_q    <= grant_dm && dm_we_i;
                addr_q  <= grant_dm ? dm_addr_i : if_addr_i;
                wdata_q <= grant_dm ? dm_wdata_i : '0;
                last_dm <= grant_dm;
            end
            if (state == ACCESS && cnt_zero) begin
                if (sel == SEL_DM) dm_rdata_o <= we_q ? '0 : mem_rdata_i;
                else if_rdata_o <= mem_rdata_i;
            end
        end
    // memory strobes, ready pulses and the pipeline stall
    always_comb begin
        mem_en_o    = state == ACCESS;
        mem_we_o    = mem_en_o && cnt_zero && we_q;
        mem_addr_o  = mem_en_o ? addr_q : '0;
        mem_wdata_o = mem_en_o ? wdata_q : '0;
        if_ready_o  = state == DONE && sel == SEL_IF;
        dm_ready_o  = state == DONE && sel == SEL_DM;
        stall_o     = rst_i && (if_req_i || dm_req_i) &&
                      !(if_ready_o ? !dm_req_i : (dm_ready_o && !if_req_i));
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed checks of the arbiter at MEM_LAT 2, 3 and 1
module tb_unified_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic [2:0] if_ready, dm_ready, mem_en, mem_we, stall;
    logic [31:0] if_rdata [3];
    logic [31:0] dm_rdata [3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // instance 0: MEM_LAT 2, instance 1: MEM_LAT 3, instance 2: MEM_LAT 1
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [63:0] wr = '0;
        logic [31:0] m [64];
        logic [5:0] idx;
        assign idx = mem_addr[g][7:2];
        // unwritten word i reads as 0x2002_0001 + i
        assign mem_rdata[g] = wr[idx] ? m[idx] : 32'h2002_0001 + 32'(idx);
        always @(posedge clk)
            if (mem_we[g]) begin
                m[idx]  <= mem_wdata[g];
                wr[idx] <= 1'b1;
            end
        unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 2 : (g == 1 ? 3 : 1))) u (
            .clk_i       (clk),
            .rst_i       (rst_n),
            .if_req_i    (if_req),
            .if_addr_i   (if_addr),
            .if_ready_o  (if_ready[g]),
            .if_rdata_o  (if_rdata[g]),
            .dm_req_i    (dm_req),
            .dm_we_i     (dm_we),
            .dm_addr_i   (dm_addr),
            .dm_wdata_i  (dm_wdata),
            .dm_ready_o  (dm_ready[g]),
            .dm_rdata_o  (dm_rdata[g]),
            .mem_en_o    (mem_en[g]),
            .mem_we_o    (mem_we[g]),
            .mem_addr_o  (mem_addr[g]),
            .mem_wdata_o (mem_wdata[g]),
            .mem_rdata_i (mem_rdata[g]),
            .stall_o     (stall[g])
        );
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        if_req = 1'b1;
        dm_req = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) begin
            tests++; if ({if_ready[g], dm_ready[g], mem_en[g], mem_we[g], stall[g]} !== 5'b0) begin
                fails++; $display("FAIL reset_ctrl[%0d]: got %b want 00000", g, {if_ready[g], dm_ready[g], mem_en[g], mem_we[g], stall[g]});
            end
            tests++; if (if_rdata[g] !== 32'h0 || dm_rdata[g] !== 32'h0) begin
                fails++; $display("FAIL reset_rdata[%0d]: got %h/%h want 0/0", g, if_rdata[g], dm_rdata[g]);
            end
            tests++; if (mem_addr[g] !== 32'h0 || mem_wdata[g] !== 32'h0) begin
                fails++; $display("FAIL reset_mem_bus[%0d]: got %h/%h want 0/0", g, mem_addr[g], mem_wdata[g]);
            end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        do_reset();
        if_req = 1'b1;
        if_addr = 32'h10;
        #1;
        tests++; if (stall[0] !== 1'b1) begin fails++; $display("FAIL fetch_stall_t0: got %b want 1", stall[0]); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            tests++; if (mem_en[0] !== (k <= 2)) begin fails++; $display("FAIL fetch_en k=%0d: got %b want %b", k, mem_en[0], k <= 2); end
            tests++; if (if_ready[0] !== (k == 3)) begin fails++; $display("FAIL fetch_ready k=%0d: got %b want %b", k, if_ready[0], k == 3); end
            tests++; if (stall[0] !== (k < 3)) begin fails++; $display("FAIL fetch_stall k=%0d: got %b want %b", k, stall[0], k < 3); end
            if (k == 1) begin
                tests++; if (mem_addr[0] !== 32'h10) begin fails++; $display("FAIL fetch_addr: got %h want 00000010", mem_addr[0]); end
            end
        end
        tests++; if (if_rdata[0] !== 32'h2002_0005) begin fails++; $display("FAIL fetch_rdata: got %h want 20020005", if_rdata[0]); end
        if_req = 1'b0;
        @(negedge clk);
        tests++; if (if_ready[0] !== 1'b0) begin fails++; $display("FAIL fetch_pulse_width: got %b want 0", if_ready[0]); end
        tests++; if (if_rdata[0] !== 32'h2002_0005) begin fails++; $display("FAIL fetch_rdata_hold: got %h want 20020005", if_rdata[0]); end
    endtask

    task automatic test_store_load();
        int wes = 0;
        do_reset();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (mem_we[0]) begin
                wes++;
                tests++; if (mem_wdata[0] !== 32'hDEAD_BEEF || k != 2) begin fails++; $display("FAIL store_strobe k=%0d: got %h want deadbeef at k=2", k, mem_wdata[0]); end
            end
            tests++; if (dm_ready[0] !== (k == 3)) begin fails++; $display("FAIL store_ready k=%0d: got %b want %b", k, dm_ready[0], k == 3); end
        end
        tests++; if (wes != 1) begin fails++; $display("FAIL store_we_count: got %0d want 1", wes); end
        tests++; if (dm_rdata[0] !== 32'h0) begin fails++; $display("FAIL store_rdata: got %h want 00000000", dm_rdata[0]); end
        dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        dm_req = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1111_2222;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (mem_we[0]) wes++;
            tests++; if (dm_ready[0] !== (k == 3)) begin fails++; $display("FAIL load_ready k=%0d: got %b want %b", k, dm_ready[0], k == 3); end
        end
        tests++; if (wes != 1) begin fails++; $display("FAIL load_we_count: got %0d want 1", wes); end
        tests++; if (dm_rdata[0] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL load_rdata: got %h want deadbeef", dm_rdata[0]); end
        dm_req = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            tests++; if (dm_ready[0] !== (k == 3)) begin fails++; $display("FAIL simul_dm_ready k=%0d: got %b want %b", k, dm_ready[0], k == 3); end
            tests++; if (if_ready[0] !== (k == 7)) begin fails++; $display("FAIL simul_if_ready k=%0d: got %b want %b", k, if_ready[0], k == 7); end
            tests++; if (stall[0] !== (k < 7)) begin fails++; $display("FAIL simul_stall k=%0d: got %b want %b", k, stall[0], k < 7); end
            if (k == 3) dm_req = 1'b0;
        end
        tests++; if (dm_rdata[0] !== 32'h2002_0009) begin fails++; $display("FAIL simul_dm_rdata: got %h want 20020009", dm_rdata[0]); end
        tests++; if (if_rdata[0] !== 32'h2002_0005) begin fails++; $display("FAIL simul_if_rdata: got %h want 20020005", if_rdata[0]); end
        if_req = 1'b0;
    endtask

    task automatic test_fairness();
        int n = 0;
        logic exp_dm;
        do_reset();
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        for (int k = 1; k <= 20 && n < 4; k++) begin
            @(negedge clk);
            if (if_ready[0] || dm_ready[0]) begin
                exp_dm = (n % 2) == 0;
                tests++; if (dm_ready[0] !== exp_dm || if_ready[0] !== !exp_dm) begin
                    fails++; $display("FAIL fair_order #%0d: got dm=%b if=%b want dm=%b", n, dm_ready[0], if_ready[0], exp_dm);
                end
                tests++; if (k != 4 * n + 3) begin fails++; $display("FAIL fair_timing #%0d: got k=%0d want %0d", n, k, 4 * n + 3); end
                n++;
            end
        end
        tests++; if (n != 4) begin fails++; $display("FAIL fair_count: got %0d grants want 4", n); end
        if_req = 1'b0; dm_req = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        do_reset();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1234_5678;
        @(negedge clk);
        tests++; if (mem_en[1] !== 1'b1) begin fails++; $display("FAIL abort_pre_en: got %b want 1", mem_en[1]); end
        rst_n = 1'b0;
        #1;
        tests++; if ({mem_en[1], mem_we[1], stall[1], dm_ready[1]} !== 4'b0) begin
            fails++; $display("FAIL abort_ctrl: got %b want 0000", {mem_en[1], mem_we[1], stall[1], dm_ready[1]});
        end
        tests++; if (mem_addr[1] !== 32'h0 || mem_wdata[1] !== 32'h0) begin fails++; $display("FAIL abort_bus: got %h/%h want 0/0", mem_addr[1], mem_wdata[1]); end
        dm_req = 1'b0; dm_we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            tests++; if (mem_we[1] !== 1'b0 || mem_en[1] !== 1'b0) begin fails++; $display("FAIL abort_post k=%0d: got en=%b we=%b want 0/0", k, mem_en[1], mem_we[1]); end
        end
        if_req = 1'b1; if_addr = 32'h10;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            tests++; if (if_ready[1] !== (k == 4)) begin fails++; $display("FAIL abort_idle_fetch k=%0d: got %b want %b", k, if_ready[1], k == 4); end
        end
        tests++; if (if_rdata[1] !== 32'h2002_0005) begin fails++; $display("FAIL abort_fetch_rdata: got %h want 20020005", if_rdata[1]); end
        if_req = 1'b0;
    endtask

    task automatic test_lat1();
        do_reset();
        if_req = 1'b1; if_addr = 32'h10;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            tests++; if (mem_en[2] !== (k == 1 || k == 4)) begin fails++; $display("FAIL lat1_en k=%0d: got %b want %b", k, mem_en[2], k == 1 || k == 4); end
            tests++; if (if_ready[2] !== (k == 2 || k == 5)) begin fails++; $display("FAIL lat1_ready k=%0d: got %b want %b", k, if_ready[2], k == 2 || k == 5); end
            if (k == 2) begin
                tests++; if (if_rdata[2] !== 32'h2002_0005) begin fails++; $display("FAIL lat1_rdata0: got %h want 20020005", if_rdata[2]); end
                if_addr = 32'h14;
            end
        end
        tests++; if (if_rdata[2] !== 32'h2002_0006) begin fails++; $display("FAIL lat1_rdata1: got %h want 20020006", if_rdata[2]); end
        if_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_load();
        test_simultaneous();
        test_fairness();
        test_reset_mid_store();
        test_lat1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
